mux_scan_capture: RTL and testbench

Parametrised, clocked successor to the 2:1 mux / latched-mux cells. It selects one of CHANNELS input words of WIDTH bits and applies optional per-channel inversion. The result is captured into a holdable output register. An autonomous scan mode steps through every channel and presents each captured word on a valid/ready output port. The block sits between the custom-cell test structures and the on-chip readout logic.

---
 rtl/mux_scan_capture.sv | 144 ++++++++++++++
 tb/tb_mux_scan_capture.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_capture.sv
// Channel mux with per-channel inversion into a holdable capture register,
// plus an autonomous scan that presents every channel on a valid/ready port.
module mux_scan_capture #(
  parameter int  WIDTH    = 8,
  parameter int  CHANNELS = 4,
  localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS*WIDTH-1:0]  ch_data,
  input  logic [CHANNELS-1:0]        inv_mask,
  input  logic [SELW-1:0]            sel,
  input  logic                       mode,
  input  logic                       hold,
  input  logic                       start,
  input  logic                       abort,
  output logic [WIDTH-1:0]           out_data,
  output logic [SELW-1:0]            out_chan,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_PRESENT, S_DONE} state_t;

  localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

  // Handshake: a beat transfers on a rising edge where out_valid & out_ready
  // are both high and abort is low; out_data/out_chan never change while
  // out_valid is high and no transfer or abort has happened.

  state_t            state_q, state_d;
  logic [SELW-1:0]   idx_q, idx_d;
  logic [SELW-1:0]   chan_q, chan_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic [SELW-1:0]   mux_idx;
  logic [WIDTH-1:0]  mux_word;
  logic              hs;
  logic              scan_go;

  assign hs      = valid_q & out_ready;
  assign scan_go = start & mode;
  assign mux_idx = (state_q == S_IDLE) ? sel : idx_q;

  // Out-of-range indices select an all-zero word.
  always_comb begin
    mux_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (mux_idx == SELW'(c)) begin
        mux_word = ch_data[c*WIDTH +: WIDTH] ^ {WIDTH{inv_mask[c]}};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (scan_go) state_d = S_SAMPLE;
      S_SAMPLE: begin
        if (abort)      state_d = S_IDLE;
        else if (!hold) state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (abort)   state_d = S_IDLE;
        else if (hs) state_d = (idx_q == LAST) ? S_DONE : S_SAMPLE;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_SAMPLE) || (state_q == S_PRESENT);
    done      = (state_q == S_DONE);
    dbg_state = state_q;
  end

  always_comb begin
    idx_d   = idx_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (scan_go) begin
          idx_d = '0;
        end else if (!hold) begin
          data_d = mux_word;
          chan_d = sel;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          idx_d = '0;
        end else if (!hold) begin
          data_d  = mux_word;
          chan_d  = idx_q;
          valid_d = 1'b1;
        end
      end
      S_PRESENT: begin
        if (abort) begin
          valid_d = 1'b0;
          idx_d   = '0;
        end else if (hs) begin
          valid_d = 1'b0;
          if (idx_q != LAST) idx_d = idx_q + 1'b1;
        end
      end
      S_DONE:  idx_d = '0;
      default: idx_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Directed bench for mux_scan_capture: per-cycle comparison against a
// transaction-level model plus a beat scoreboard and literal spot checks.
module tb_mux_scan_capture;

  localparam int W    = 8;
  localparam int CH   = 4;
  localparam int SELW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH*W-1:0]   ch_data;
  logic [CH-1:0]     inv_mask;
  logic [SELW-1:0]   sel;
  logic              mode, hold, start, abort, out_ready;
  logic [W-1:0]      out_data;
  logic [SELW-1:0]   out_chan;
  logic              out_valid, busy, done;
  logic [1:0]        dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [SELW+W-1:0] exp_q[$];
  int                beat_cyc[$];

  // Model: scan progress kept as "active / holding a beat / next channel".
  bit          m_active = 0, m_valid = 0, m_done = 0;
  int          m_next   = 0;
  logic [W-1:0] m_data  = '0;
  int          m_chan   = 0;

  mux_scan_capture #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .inv_mask(inv_mask), .sel(sel),
    .mode(mode), .hold(hold), .start(start), .abort(abort),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] word(int c);
    if (c >= CH) return '0;
    return ch_data[c*W +: W] ^ {W{inv_mask[c]}};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_valid = 0; m_done = 0; m_next = 0; m_data = '0; m_chan = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start && mode) begin
        m_active = 1; m_next = 0;
      end else if (!hold) begin
        m_data = word(int'(sel)); m_chan = int'(sel);
      end
    end else if (abort) begin
      m_active = 0; m_valid = 0;
    end else if (!m_valid) begin
      if (!hold) begin
        m_data = word(m_next); m_chan = m_next; m_valid = 1;
      end
    end else if (out_ready) begin
      m_valid = 0;
      if (m_next == CH - 1) begin
        m_active = 0; m_done = 1;
      end else begin
        m_next++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Outputs settle well after the rising edge; inputs change at negedge+1.
  always @(negedge clk) begin
    #2;
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_chan", 32'(out_chan), 32'(m_chan));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_active));
    chk("done", 32'(done), 32'(m_done));
    if (out_valid && out_ready && !abort && !rst) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL beat: unexpected chan %0d data %0h, none expected", out_chan, out_data);
      end else begin
        chk("beat", 32'({out_chan, out_data}), 32'(exp_q.pop_front()));
      end
      beat_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_beats(input int first, input int last, input logic [CH-1:0] inv);
    logic [CH*W-1:0] base;
    base = 32'h4433_2211;
    for (int c = first; c <= last; c++) begin
      exp_q.push_back({SELW'(c), base[c*W +: W] ^ {W{inv[c]}}});
    end
  endtask

  task automatic pulse_start();
    start = 1; mode = 1;
    step();
    start = 0; mode = 0;
  endtask

  task automatic wait_beat(input int ch);
    int i;
    for (i = 0; i < 40; i++) begin
      if (out_valid && int'(out_chan) == ch) break;
      step();
    end
    chk("wait_beat_timeout", 32'(i < 40), 32'd1);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 60; i++) begin
      if (done) break;
      step();
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1; ch_data = '0; inv_mask = '0; sel = '0; mode = 0; hold = 0;
    start = 0; abort = 0; out_ready = 0;
    step(); step();
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_chan", 32'(out_chan), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 0;

    // Direct mode.
    ch_data = 32'h4433_2211; inv_mask = 4'b0000; sel = 2; hold = 0;
    step();
    chk("direct_data", 32'(out_data), 32'h33);
    chk("direct_chan", 32'(out_chan), 32'd2);
    chk("direct_valid", 32'(out_valid), 32'd0);

    // Hold then inversion.
    hold = 1; step();
    sel = 0; inv_mask = 4'b0001; step(); step();
    chk("hold_data", 32'(out_data), 32'h33);
    chk("hold_chan", 32'(out_chan), 32'd2);
    hold = 0; step();
    chk("inv_data", 32'(out_data), 32'hEE);
    chk("inv_chan", 32'(out_chan), 32'd0);

    // Full scan at full throughput.
    inv_mask = 4'b1000; out_ready = 1;
    push_beats(0, 3, 4'b1000);
    beat_cyc.delete();
    pulse_start();
    wait_done();
    chk("scan_beats", 32'(beat_cyc.size()), 32'd4);
    for (int i = 1; i < beat_cyc.size(); i++)
      chk("beat_spacing", 32'(beat_cyc[i] - beat_cyc[i-1]), 32'd2);
    chk("scan_q_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure on beat 1 while ch_data churns.
    out_ready = 0;
    push_beats(0, 3, 4'b1000);
    pulse_start();
    wait_beat(0);
    out_ready = 1; step();
    out_ready = 0; step();
    for (int i = 0; i < 5; i++) begin
      ch_data = $urandom();
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h22);
      chk("bp_chan", 32'(out_chan), 32'd1);
    end
    ch_data = 32'h4433_2211; out_ready = 1;
    wait_done();
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // Start pulsed mid-scan plus hold stalls in SAMPLE.
    push_beats(0, 3, 4'b1000);
    pulse_start();
    hold = 1; step(); step(); hold = 0;
    step(); step(); step();
    start = 1; mode = 1; step(); start = 0; mode = 0;
    wait_done();
    chk("midstart_q_empty", 32'(exp_q.size()), 32'd0);

    // Abort during PRESENT of beat 2 with out_ready high.
    push_beats(0, 1, 4'b1000);
    pulse_start();
    wait_beat(2);
    abort = 1; step(); abort = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    step(); step();
    chk("abort_q_empty", 32'(exp_q.size()), 32'd0);

    // Async reset during SAMPLE of beat 2.
    push_beats(0, 1, 4'b1000);
    pulse_start();
    wait_beat(1);
    step();
    #2 rst = 1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_chan", 32'(out_chan), 32'd0);
    step();
    rst = 0;
    chk("arst_q_empty", 32'(exp_q.size()), 32'd0);
    push_beats(0, 3, 4'b1000);
    pulse_start();
    wait_done();
    chk("rescan_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
